multicycle_ctrl: RTL

- Sequencing controller for the multicycle RISC-V datapath.
- Replaces the single-cycle opcode decoder with a state machine that steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB over several clocks.
- Waits on a shared single-port memory through a ready handshake and guards that wait with a timeout counter.
- Sits between the instruction register (opcode), the ALU (zero flag) and the shared memory, and drives every datapath enable and mux select.

---
 rtl/multicycle_ctrl.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// ---------------------------------------------------------------------------
// Sequencing controller for the multicycle RISC-V datapath. Each instruction
// is stepped through FETCH, DECODE, EXEC, MEM and WB over several clocks, and
// every datapath enable and mux select is decoded from the state register
// and the opcode latched in DECODE.
//
// Memory handshake: in FETCH and MEM the controller holds mem_read or
// mem_write high and stable; the access completes in any cycle where
// mem_ready=1 is seen together with the request. If the access has not
// completed after MEM_TIMEOUT cycles of waiting, mem_err pulses for one
// cycle, the request is dropped in that same cycle, and the controller
// returns to FETCH without retiring the instruction.
//
// Optional feature: define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to send unknown
// opcodes to a sticky TRAP state (left only through arst). When the macro is
// undefined, unknown opcodes retire as a NOP and TRAP is unreachable.
//
// Parameters:
//   MEM_TIMEOUT  max cycles waiting for mem_ready in FETCH/MEM (2..255)
// Ports:
//   clk         clock, rising edge
//   arst        asynchronous active-high reset
//   opcode      instr[6:0] from the instruction register (sampled in DECODE)
//   alu_zero    ALU zero flag (BRANCH_EQ in EXEC)
//   mem_ready   memory completes the current access this cycle
//   pc_write, ir_write, i_or_d, mem_read, mem_write, mem_2_reg, reg_write,
//   alu_src, alu_op[1:0], branch, jump   datapath controls
//   instr_done  one-cycle pulse when an instruction retires
//   mem_err     one-cycle pulse on memory timeout
//   state[2:0]  current state (IDLE=0 .. TRAP=6), for debug
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       arst,
    input  logic [6:0] opcode,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_2_reg,
    output logic       reg_write,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       branch,
    output logic       jump,
    output logic       instr_done,
    output logic       mem_err,
    output logic [2:0] state
);

    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BEQ    = 7'b1100011;
    localparam logic [6:0] OP_JUMP   = 7'b1101111;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [6:0] r_opcode;
    logic [7:0] r_wait;
    logic       r_idle_seen;   // IDLE has already spanned one edge
    logic       w_waiting;
    logic       w_timeout;

    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
    assign w_timeout = w_waiting && (r_wait == WAIT_LAST);

    // State register, latched opcode, wait counter.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state     <= S_IDLE;
            r_opcode    <= 7'd0;
            r_wait      <= 8'd0;
            r_idle_seen <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_idle_seen <= (r_state == S_IDLE);
            if (r_state == S_DECODE) begin
                r_opcode <= opcode;
            end
            // A timeout restarts FETCH from scratch, so it clears the
            // counter even though FETCH->FETCH is not a state change.
            if ((w_next != r_state) || mem_ready || w_timeout) begin
                r_wait <= 8'd0;
            end else if (w_waiting) begin
                r_wait <= r_wait + 8'd1;
            end
        end
    end

    // Next state and output decode.
    always_comb begin
        w_next     = r_state;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_2_reg  = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        branch     = 1'b0;
        jump       = 1'b0;
        instr_done = 1'b0;
        mem_err    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_idle_seen) begin
                    w_next = S_FETCH;
                end
            end

            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_timeout) begin
                    mem_read = 1'b0;
                    mem_err  = 1'b1;
                    w_next   = S_FETCH;
                end
            end

            S_DECODE: begin
                w_next = S_EXEC;
            end

            S_EXEC: begin
                case (r_opcode)
                    OP_ALU_R: begin
                        alu_op = 2'b10;
                        w_next = S_WB;
                    end
                    OP_ALU_I: begin
                        alu_op  = 2'b10;
                        alu_src = 1'b1;
                        w_next  = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src = 1'b1;
                        w_next  = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op     = 2'b01;
                        branch     = 1'b1;
                        pc_write   = alu_zero;
                        instr_done = 1'b1;
                        w_next     = S_FETCH;
                    end
                    OP_JUMP: begin
                        jump       = 1'b1;
                        pc_write   = 1'b1;
                        reg_write  = 1'b1;
                        instr_done = 1'b1;
                        w_next     = S_FETCH;
                    end
                    default: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                        w_next = S_TRAP;
`else
                        instr_done = 1'b1;
                        w_next     = S_FETCH;
`endif
                    end
                endcase
            end

            S_MEM: begin
                // Only LOAD and STORE reach MEM.
                i_or_d  = 1'b1;
                alu_src = 1'b1;
                if (r_opcode == OP_LOAD) begin
                    mem_read = 1'b1;
                end else begin
                    mem_write = 1'b1;
                end
                if (mem_ready) begin
                    if (r_opcode == OP_LOAD) begin
                        w_next = S_WB;
                    end else begin
                        instr_done = 1'b1;
                        w_next     = S_FETCH;
                    end
                end else if (w_timeout) begin
                    mem_read  = 1'b0;
                    mem_write = 1'b0;
                    mem_err   = 1'b1;
                    w_next    = S_FETCH;
                end
            end

            S_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
                case (r_opcode)
                    OP_LOAD:  mem_2_reg = 1'b1;
                    OP_ALU_R: alu_op = 2'b10;
                    OP_ALU_I: begin
                        alu_op  = 2'b10;
                        alu_src = 1'b1;
                    end
                    default: ;
                endcase
            end

            S_TRAP: begin
                w_next = S_TRAP;
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign state = r_state;

endmodule
